ninjakun_rom_loader: RTL and testbench
======================================

# ninjakun_rom_loader

Sits between `hps_io`'s ioctl download stream and the game core. It splits ROM download bytes (index 0) into four ROM regions and writes them to the core through a valid/busy handshake. It also captures the 8 MRA DIP bytes (index 254) and sequences the core reset, holding it through the download plus a fixed settle period.

## Interface
Parameters:
- `RGN1_BASE`, default 25'h0C000: first byte address of region 1 (region 0 starts at 0).
- `RGN2_BASE`, default 25'h14000: first byte address of region 2.
- `RGN3_BASE`, default 25'h1C000: first byte address of region 3.
- `ROM_END`, default 25'h24000: first address past the ROM image; bytes at or above it are dropped.
- `HOLD_CYCLES`, default 16: core-reset extension after download ends, in clk_sys cycles, range 1..255.

Ports:
- `clk_sys`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `ioctl_download`  in  1  download active.
- `ioctl_index`  in  8  download target.
- `ioctl_wr`  in  1  one-cycle byte strobe.
- `ioctl_addr`  in  25  byte address.
- `ioctl_dout`  in  8  byte data.
- `ioctl_wait`  out  1  stall request to hps_io.
- `rom_we`  out  1  write valid; held until accepted.
- `rom_busy`  in  1  core cannot accept; a write is accepted on a cycle with `rom_we`=1 and `rom_busy`=0.
- `rom_rgn`  out  2  region select.
- `rom_addr`  out  25  offset within region.
- `rom_data`  out  8  write data.
- `dip`  out  64  DIP bytes, byte k at [8k+7:8k], active-low.
- `core_reset`  out  1  reset to the game core.
- `load_done`  out  1  high in RUN.
- `overflow`  out  1  sticky: a byte at or above `ROM_END` was dropped.
- `rom_sum`  out  16  byte checksum (see Configuration).

## Operation
- States:
  - IDLE, the reset state. Go to LOAD when `ioctl_download`=1 and index=0.
  - LOAD. Accept ROM bytes. Go to DRAIN when `ioctl_download` falls.
  - DRAIN. Wait until no write is pending, then load the hold counter with `HOLD_CYCLES` and go to HOLD.
  - HOLD. Decrement the counter each cycle. Go to RUN when the counter reaches 0.
  - RUN. Go back to LOAD on a new index-0 download.
- `core_reset` = `reset` OR (state ≠ RUN). `load_done` = (state = RUN).
- Entering LOAD clears `overflow` (and `rom_sum` when enabled).
- ROM write capture in LOAD:
  - A byte is taken on `ioctl_wr`=1, index=0, addr<`ROM_END`, into a one-entry buffer.
  - Region decode: addr≥RGN3 → 3; else ≥RGN2 → 2; else ≥RGN1 → 1; else 0.
  - `rom_addr` = addr − base of the selected region, 25-bit unsigned.
- addr≥`ROM_END`: the byte is dropped and `overflow` is set. No write is issued.
- Buffer:
  - `rom_we` asserts with the registered addr/data on the cycle after the strobe.
  - `rom_we` clears on acceptance, unless a new strobe arrives in the same cycle; then the buffer reloads and `rom_we` stays high.
- `ioctl_wait` = `rom_we` AND `rom_busy` (combinational). hps_io issues no strobe while it is high. A strobe that arrives anyway while the buffer is full and unaccepted is dropped and sets `overflow`.
- DIP capture: index=254, addr[24:3]=0 → `dip` byte addr[2:0] ← data. This happens in any state and never affects the FSM or `rom_we`.
- ROM bytes outside LOAD are ignored.

## Timing
- Reset values:
  - state IDLE, `core_reset`=1, `rom_we`=0, `rom_rgn`=0, `rom_addr`=0, `rom_data`=0, `ioctl_wait`=0.
  - `load_done`=0, `overflow`=0, `rom_sum`=0, `dip`=64'hFFFF_FFFF_FFFF_FFFF.
- Strobe to `rom_we` latency is 1 cycle. With `rom_busy`=0 throughput is one byte per cycle.
- Download end to `load_done`:
  - 1 cycle to DRAIN, plus the pending drain time.
  - Then 1 cycle to load the counter, plus `HOLD_CYCLES` cycles.
  - With no pending write, `core_reset` falls exactly `HOLD_CYCLES`+2 cycles after `ioctl_download` falls.
- `reset` mid-download: outputs go to reset values immediately; the buffered byte is discarded.
- New download starting during HOLD: go to LOAD directly; the counter is abandoned.

## Configuration
- `NINJAKUN_ROM_CHECKSUM_EN` defined: `rom_sum` accumulates the mod-2^16 sum of every accepted ROM byte. It is updated on acceptance, cleared on LOAD entry, and frozen otherwise.
- Not defined: `rom_sum` is constant 0 and the accumulator is not built.

## Test plan
- 4 bytes at addr 0x0BFFE..0x0C001, `rom_busy`=0 → rom_we on the 4 following cycles; (rgn, addr) = (0,0xBFFE), (0,0xBFFF), (1,0), (1,1).
- Byte at 0x1C005, data 0x5A, `rom_busy` high for 3 cycles → `rom_we` and `ioctl_wait` high for 3 cycles; accepted on the 4th with rgn 3, addr 5, data 0x5A.
- Download ends with the buffer empty, `HOLD_CYCLES`=16 → `core_reset` falls and `load_done` rises 18 cycles after `ioctl_download` falls.
- Index 254, addr 2, data 0xC3 during RUN → `dip[23:16]`=0xC3; `core_reset` stays 0.
- Byte at 0x24000 → no `rom_we`, `overflow`=1; next index-0 download clears it.
- With checksum enabled, bytes 0xFF, 0x02 → `rom_sum`=0x0101. `reset` pulsed mid-download → `rom_sum`=0, `dip` all FF, state IDLE.

Source files
------------

// File: rtl/ninjakun_rom_loader.sv
// ninjakun_rom_loader: routes the hps_io ioctl download stream into the game core.
// Index-0 bytes are split into four ROM regions and handed to the core through a
// one-entry valid/busy buffer. Index-254 bytes land in the 64-bit DIP register.
// The core reset is held through the download plus a fixed settle period.
// Optional feature: define NINJAKUN_ROM_CHECKSUM_EN to build the rom_sum accumulator.
module ninjakun_rom_loader #(
  parameter logic [24:0] RGN1_BASE   = 25'h0C000,
  parameter logic [24:0] RGN2_BASE   = 25'h14000,
  parameter logic [24:0] RGN3_BASE   = 25'h1C000,
  parameter logic [24:0] ROM_END     = 25'h24000,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        rom_we,
  input  logic        rom_busy,
  output logic [1:0]  rom_rgn,
  output logic [24:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic [63:0] dip,
  output logic        core_reset,
  output logic        load_done,
  output logic        overflow,
  output logic [15:0] rom_sum
);

  localparam logic [7:0] HoldInit = 8'(HOLD_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDrain,
    StHold,
    StRun
  } state_e;

  state_e      state_q;
  logic [7:0]  hold_cnt_q;

  logic        rom_we_q, rom_we_d;
  logic [1:0]  rom_rgn_q, rom_rgn_d;
  logic [24:0] rom_addr_q, rom_addr_d;
  logic [7:0]  rom_data_q, rom_data_d;
  logic        overflow_q, overflow_d;
  logic [63:0] dip_q;

  logic        rom_start;
  logic        enter_load;
  logic        accept;
  logic        rom_strobe;
  logic        in_range;
  logic        buf_free;
  logic        load_buf;
  logic        drop;
  logic        dip_wr;
  logic [1:0]  rgn_dec;
  logic [24:0] rgn_base;

  // Handshake and capture qualifiers.
  always_comb begin
    rom_start  = ioctl_download && (ioctl_index == 8'd0);
    enter_load = rom_start && (state_q inside {StIdle, StHold, StRun});
    accept     = rom_we_q && !rom_busy;
    rom_strobe = ioctl_wr && (ioctl_index == 8'd0) && (state_q == StLoad);
    in_range   = ioctl_addr < ROM_END;
    // The buffer can take a byte if it is empty or being emptied this cycle.
    buf_free   = !rom_we_q || accept;
    load_buf   = rom_strobe && in_range && buf_free;
    drop       = rom_strobe && (!in_range || !buf_free);
    dip_wr     = ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr[24:3] == 22'd0);
  end

  // Region decode: highest base not above the address wins.
  always_comb begin
    rgn_dec  = 2'd0;
    rgn_base = 25'd0;
    if (ioctl_addr >= RGN3_BASE) begin
      rgn_dec  = 2'd3;
      rgn_base = RGN3_BASE;
    end else if (ioctl_addr >= RGN2_BASE) begin
      rgn_dec  = 2'd2;
      rgn_base = RGN2_BASE;
    end else if (ioctl_addr >= RGN1_BASE) begin
      rgn_dec  = 2'd1;
      rgn_base = RGN1_BASE;
    end
  end

  // Download sequencing FSM with the reset-extension counter.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      hold_cnt_q <= 8'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (rom_start) state_q <= StLoad;
        end
        StLoad: begin
          if (!ioctl_download) state_q <= StDrain;
        end
        StDrain: begin
          if (!rom_we_q) begin
            hold_cnt_q <= HoldInit;
            state_q    <= StHold;
          end
        end
        StHold: begin
          if (rom_start) begin
            state_q <= StLoad;
          end else begin
            hold_cnt_q <= hold_cnt_q - 8'd1;
            // Leaving on the decrement to zero gives HOLD_CYCLES cycles in HOLD.
            if (hold_cnt_q <= 8'd1) state_q <= StRun;
          end
        end
        StRun: begin
          if (rom_start) state_q <= StLoad;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Next state of the one-entry write buffer and the sticky overflow flag.
  always_comb begin
    rom_we_d   = rom_we_q;
    rom_rgn_d  = rom_rgn_q;
    rom_addr_d = rom_addr_q;
    rom_data_d = rom_data_q;
    overflow_d = overflow_q;
    if (load_buf) begin
      // A reload in the acceptance cycle keeps rom_we high back to back.
      rom_we_d   = 1'b1;
      rom_rgn_d  = rgn_dec;
      rom_addr_d = ioctl_addr - rgn_base;
      rom_data_d = ioctl_dout;
    end else if (accept) begin
      rom_we_d = 1'b0;
    end
    if (enter_load) begin
      overflow_d = 1'b0;
    end else if (drop) begin
      overflow_d = 1'b1;
    end
  end

  // Write buffer and overflow registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rom_we_q   <= 1'b0;
      rom_rgn_q  <= 2'd0;
      rom_addr_q <= 25'd0;
      rom_data_q <= 8'd0;
      overflow_q <= 1'b0;
    end else begin
      rom_we_q   <= rom_we_d;
      rom_rgn_q  <= rom_rgn_d;
      rom_addr_q <= rom_addr_d;
      rom_data_q <= rom_data_d;
      overflow_q <= overflow_d;
    end
  end

  // DIP bytes are captured in any state; switches are active-low so reset is all ones.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dip_q <= '1;
    end else if (dip_wr) begin
      dip_q[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
    end
  end

`ifdef NINJAKUN_ROM_CHECKSUM_EN
  logic [15:0] sum_q;

  // Running mod-2^16 sum of accepted bytes, restarted with each ROM download.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sum_q <= 16'd0;
    end else if (enter_load) begin
      sum_q <= 16'd0;
    end else if (accept) begin
      sum_q <= sum_q + {8'd0, rom_data_q};
    end
  end

  assign rom_sum = sum_q;
`else
  assign rom_sum = 16'd0;
`endif

  assign rom_we     = rom_we_q;
  assign rom_rgn    = rom_rgn_q;
  assign rom_addr   = rom_addr_q;
  assign rom_data   = rom_data_q;
  assign ioctl_wait = rom_we_q && rom_busy;
  assign dip        = dip_q;
  assign overflow   = overflow_q;
  assign core_reset = reset || (state_q != StRun);
  assign load_done  = (state_q == StRun);

endmodule

// File: tb/tb_ninjakun_rom_loader.sv
// Self-checking bench for ninjakun_rom_loader: directed vector table, stall and
// reset-timing sequences, and a randomized download checked by a scoreboard.
module tb_ninjakun_rom_loader;

  localparam logic [24:0] R1   = 25'h0C000;
  localparam logic [24:0] R2   = 25'h14000;
  localparam logic [24:0] R3   = 25'h1C000;
  localparam logic [24:0] REND = 25'h24000;
  localparam int unsigned HOLD = 16;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        rom_we;
  logic        rom_busy;
  logic [1:0]  rom_rgn;
  logic [24:0] rom_addr;
  logic [7:0]  rom_data;
  logic [63:0] dip;
  logic        core_reset;
  logic        load_done;
  logic        overflow;
  logic [15:0] rom_sum;

  ninjakun_rom_loader #(
    .RGN1_BASE  (R1),
    .RGN2_BASE  (R2),
    .RGN3_BASE  (R3),
    .ROM_END    (REND),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_wait    (ioctl_wait),
    .rom_we        (rom_we),
    .rom_busy      (rom_busy),
    .rom_rgn       (rom_rgn),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .dip           (dip),
    .core_reset    (core_reset),
    .load_done     (load_done),
    .overflow      (overflow),
    .rom_sum       (rom_sum)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [1:0]  rgn;
    logic [24:0] off;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic [1:0]  rgn;
    logic [24:0] off;
  } vec_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  vec_t        vecs[9];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_sum;
  logic        exp_ovf;
  logic [63:0] exp_dip;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference map: region is the count of region bases at or below the address.
  function automatic wr_t model_map(input logic [24:0] a, input logic [7:0] d);
    logic [24:0] bases[4];
    int          r;
    wr_t         res;
    bases[0] = 25'd0;
    bases[1] = R1;
    bases[2] = R2;
    bases[3] = R3;
    r = 0;
    for (int i = 1; i < 4; i++) if (a >= bases[i]) r = i;
    res.rgn  = 2'(r);
    res.off  = a - bases[r];
    res.data = d;
    return res;
  endfunction

  function automatic logic [15:0] sum_out();
`ifdef NINJAKUN_ROM_CHECKSUM_EN
    return exp_sum;
`else
    return 16'd0;
`endif
  endfunction

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic strobe(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
  endtask

  // Scoreboard: every accepted write must be the next one the model expects.
  always @(negedge clk_sys) begin
    if (!reset && rom_we && !rom_busy) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got rgn=%0d addr=%0h data=%0h expected none",
                 rom_rgn, rom_addr, rom_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("accepted_write", {rom_rgn, rom_addr, rom_data}, mon_e);
      end
    end
  end

  initial begin
    int          got;
    int unsigned sel;
    logic [24:0] a;
    logic [7:0]  d;

    vecs[0] = '{25'h0BFFE, 8'h11, 2'd0, 25'h0BFFE};
    vecs[1] = '{25'h0BFFF, 8'h22, 2'd0, 25'h0BFFF};
    vecs[2] = '{25'h0C000, 8'h33, 2'd1, 25'h00000};
    vecs[3] = '{25'h0C001, 8'h44, 2'd1, 25'h00001};
    vecs[4] = '{25'h13FFF, 8'h55, 2'd1, 25'h07FFF};
    vecs[5] = '{25'h14000, 8'h66, 2'd2, 25'h00000};
    vecs[6] = '{25'h1BFFF, 8'h77, 2'd2, 25'h07FFF};
    vecs[7] = '{25'h1C000, 8'h88, 2'd3, 25'h00000};
    vecs[8] = '{25'h23FFF, 8'h99, 2'd3, 25'h07FFF};

    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; rom_busy = 1'b0;
    exp_sum = 16'd0; exp_ovf = 1'b0; exp_dip = '1;

    // Reset values.
    repeat (3) step();
    @(negedge clk_sys);
    check("rst_core_reset", core_reset, 1);
    check("rst_rom_we", rom_we, 0);
    check("rst_word", {rom_rgn, rom_addr, rom_data}, 0);
    check("rst_wait", ioctl_wait, 0);
    check("rst_load_done", load_done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_rom_sum", rom_sum, 0);
    check("rst_dip", dip, exp_dip);
    step();
    reset = 1'b0;
    step();
    @(negedge clk_sys);
    check("idle_core_reset", core_reset, 1);

    // First download: table of region boundary bytes, back to back.
    step();
    ioctl_download = 1'b1;
    ioctl_index    = 8'd0;
    step();
    for (int i = 0; i <= 9; i++) begin
      step();
      if (i < 9) begin
        strobe(vecs[i].addr, vecs[i].data);
        exp_q.push_back(wr_t'{vecs[i].rgn, vecs[i].off, vecs[i].data});
        exp_sum += 16'(vecs[i].data);
      end else begin
        ioctl_wr = 1'b0;
      end
      @(negedge clk_sys);
      if (i > 0) begin
        check("vec_we", rom_we, 1);
        check("vec_word", {rom_rgn, rom_addr, rom_data},
              {vecs[i-1].rgn, vecs[i-1].off, vecs[i-1].data});
      end
    end
    step();
    @(negedge clk_sys);
    check("vec_we_clear", rom_we, 0);

    // Stall: busy for three rom_we cycles, plus a protocol-violating strobe that is dropped.
    step();
    strobe(25'h1C005, 8'h5A);
    rom_busy = 1'b1;
    exp_q.push_back(wr_t'{2'd3, 25'd5, 8'h5A});
    exp_sum += 16'h5A;
    for (int c = 0; c < 3; c++) begin
      step();
      if (c == 2) strobe(25'h00010, 8'hEE);
      else ioctl_wr = 1'b0;
      @(negedge clk_sys);
      check("stall_we", rom_we, 1);
      check("stall_wait", ioctl_wait, 1);
    end
    step();
    ioctl_wr = 1'b0;
    rom_busy = 1'b0;
    exp_ovf  = 1'b1;
    @(negedge clk_sys);
    check("stall_release_wait", ioctl_wait, 0);
    check("stall_word", {rom_we, rom_rgn, rom_addr, rom_data}, {1'b1, 2'd3, 25'd5, 8'h5A});
    check("full_drop_overflow", overflow, exp_ovf);
    step();
    @(negedge clk_sys);
    check("stall_we_clear", rom_we, 0);

    // Download end with empty buffer: core_reset falls HOLD+2 cycles later.
    step();
    ioctl_download = 1'b0;
    for (int k = 0; k <= int'(HOLD) + 2; k++) begin
      @(negedge clk_sys);
      check("hold_core_reset", core_reset, (k < int'(HOLD) + 2) ? 1 : 0);
      check("hold_load_done", load_done, (k < int'(HOLD) + 2) ? 0 : 1);
    end
    check("run_rom_sum", rom_sum, sum_out());
    check("run_overflow", overflow, exp_ovf);

    // DIP write in RUN; second write has addr[24:3] != 0 and is ignored.
    step();
    ioctl_download = 1'b1;
    ioctl_index    = 8'd254;
    strobe(25'd2, 8'hC3);
    exp_dip[23:16] = 8'hC3;
    step();
    strobe(25'h0A, 8'h11);
    step();
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index = 8'd0;
    @(negedge clk_sys);
    check("dip_value", dip, exp_dip);
    check("dip_core_reset", core_reset, 0);
    check("dip_rom_we", rom_we, 0);

    // New download clears overflow; out-of-range byte sets it again.
    step();
    ioctl_download = 1'b1;
    exp_sum = 16'd0;
    exp_ovf = 1'b0;
    step();
    @(negedge clk_sys);
    check("reload_overflow", overflow, exp_ovf);
    check("reload_core_reset", core_reset, 1);
    check("reload_rom_sum", rom_sum, sum_out());
    step();
    strobe(REND, 8'h77);
    exp_ovf = 1'b1;
    step();
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    check("rom_end_we", rom_we, 0);
    check("rom_end_overflow", overflow, exp_ovf);

    // Randomized stream with random busy, honouring ioctl_wait.
    for (int n = 0; n < 400; n++) begin
      step();
      rom_busy = ($urandom_range(0, 2) == 0);
      #1;
      if (!ioctl_wait && ($urandom_range(0, 3) != 0)) begin
        sel = $urandom_range(0, 7);
        case (sel)
          0:       a = REND + 25'($urandom_range(0, 3));
          1:       a = R1 - 25'd1 + 25'($urandom_range(0, 1));
          2:       a = R2 - 25'd1 + 25'($urandom_range(0, 1));
          3:       a = R3 - 25'd1 + 25'($urandom_range(0, 1));
          default: a = 25'($urandom_range(0, 32'h23FFF));
        endcase
        d = 8'($urandom);
        strobe(a, d);
        if (a < REND) begin
          exp_q.push_back(model_map(a, d));
          exp_sum += 16'(d);
        end else begin
          exp_ovf = 1'b1;
        end
      end else begin
        ioctl_wr = 1'b0;
      end
    end
    step();
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    got = 0;
    for (int c = 0; c < 400 && got == 0; c++) begin
      step();
      rom_busy = ($urandom_range(0, 2) == 0);
      @(negedge clk_sys);
      if (load_done) got = 1;
    end
    rom_busy = 1'b0;
    check("rand_load_done", got, 1);
    check("rand_queue_drained", exp_q.size(), 0);
    check("rand_overflow", overflow, exp_ovf);
    check("rand_rom_sum", rom_sum, sum_out());

    // Checksum of 0xFF + 0x02.
    step();
    ioctl_download = 1'b1;
    exp_sum = 16'd0;
    step();
    step();
    strobe(25'd0, 8'hFF);
    exp_q.push_back(model_map(25'd0, 8'hFF));
    step();
    strobe(25'd1, 8'h02);
    exp_q.push_back(model_map(25'd1, 8'h02));
    step();
    ioctl_wr = 1'b0;
    step();
    @(negedge clk_sys);
`ifdef NINJAKUN_ROM_CHECKSUM_EN
    check("sum_ff_02", rom_sum, 16'h0101);
`else
    check("sum_disabled", rom_sum, 16'h0000);
`endif

    // Reset mid-download with a stalled byte in the buffer.
    step();
    strobe(25'h100, 8'h3C);
    rom_busy = 1'b1;
    step();
    ioctl_wr = 1'b0;
    #2;
    reset = 1'b1;
    ioctl_download = 1'b0;
    exp_dip = '1;
    #1;
    check("mid_rst_rom_we", rom_we, 0);
    check("mid_rst_core_reset", core_reset, 1);
    check("mid_rst_rom_sum", rom_sum, 0);
    check("mid_rst_dip", dip, exp_dip);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_load_done", load_done, 0);
    check("mid_rst_word", {rom_rgn, rom_addr, rom_data}, 0);
    step();
    step();
    reset = 1'b0;
    rom_busy = 1'b0;
    repeat (3) step();
    @(negedge clk_sys);
    check("post_rst_idle", {core_reset, load_done, rom_we}, 3'b100);
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
